// File: rtl/riscv_boot_loader.sv
// Boot loader: packs a length-prefixed byte stream into 32-bit words, writes them to
// instruction memory and then releases the core. Optional trailing checksum: BOOT_CHECKSUM_EN.
module riscv_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_err
);

  localparam int          CW   = ADDR_W + 1;
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {HDR0, HDR1, LOAD, CSUM, FLUSH, DONE, ERR} state_t;
  localparam state_t POST = CSUM;
  logic [7:0] r_sum;
`else
  typedef enum logic [2:0] {HDR0, HDR1, LOAD, FLUSH, DONE, ERR} state_t;
  localparam state_t POST = FLUSH;
`endif

  state_t       r_state, w_next;
  logic         r_ready, r_we, r_cpu_reset, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]  r_wdata;
  logic [7:0]   r_cnt_lo;
  logic [CW-1:0] r_n, r_word_cnt;
  logic [1:0]   r_byte_cnt;
  logic [23:0]  r_word;
  logic         w_take, w_last_byte, w_last_word, w_ready_nxt;
  logic [15:0]  w_n16;

  assign w_take      = rx_valid && r_ready;
  assign w_n16       = {rx_data, r_cnt_lo};
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_last_word = (r_word_cnt == (r_n - CW'(1)));

  always_comb begin
    w_next = r_state;
    case (r_state)
      HDR0: if (w_take) w_next = HDR1;
      HDR1: if (w_take) begin
        if (w_n16 == 16'd0)              w_next = POST;
        else if ({1'b0, w_n16} > MAXW)   w_next = ERR;
        else                             w_next = LOAD;
      end
      LOAD: if (w_take && w_last_byte && w_last_word) w_next = POST;
`ifdef BOOT_CHECKSUM_EN
      CSUM: if (w_take) w_next = (rx_data == r_sum) ? FLUSH : ERR;
`endif
      FLUSH: w_next = DONE;
      default: w_next = r_state;
    endcase
    w_ready_nxt = (w_next == HDR0) || (w_next == HDR1) || (w_next == LOAD)
`ifdef BOOT_CHECKSUM_EN
                  || (w_next == CSUM)
`endif
                  ;
  end

  // Status outputs follow the current state one edge later, so the core leaves reset
  // only after the FLUSH cycle has let the final write commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= HDR0;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt_lo    <= '0;
      r_n         <= '0;
      r_word_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_word      <= '0;
`ifdef BOOT_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_state     <= w_next;
      r_ready     <= w_ready_nxt;
      r_we        <= 1'b0;
      r_cpu_reset <= (r_state != DONE);
      r_done      <= (r_state == DONE);
      r_err       <= (r_state == ERR);
      if (w_take) begin
        case (r_state)
          HDR0: r_cnt_lo <= rx_data;
          HDR1: r_n      <= w_n16[CW-1:0];
          LOAD: begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_word     <= {rx_data, r_word[23:8]};
`ifdef BOOT_CHECKSUM_EN
            r_sum      <= r_sum + rx_data;
`endif
            if (w_last_byte) begin
              r_we       <= 1'b1;
              r_addr     <= r_word_cnt[ADDR_W-1:0];
              r_wdata    <= {rx_data, r_word};
              r_word_cnt <= r_word_cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready   = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign boot_done  = r_done;
  assign boot_err   = r_err;

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Directed self-checking bench for riscv_boot_loader (default parameters).
module tb_riscv_boot_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, imem_we, cpu_reset, boot_done, boot_err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;

  int total = 0;
  int bad = 0;
  logic [7:0]  csum;
  logic [9:0]  wa[$];
  logic [31:0] wd[$];

  riscv_boot_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k = 0;
    rx_data = b; rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    if (rx_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      csum = csum + w[8*i +: 8];
      send_byte(w[8*i +: 8], gap);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wa.delete(); wd.delete();
    csum = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_valid = 1'b1; rx_data = 8'hAA;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (rx_ready !== 1'b0 || cpu_reset !== 1'b1 || imem_we !== 1'b0 || boot_done !== 1'b0 ||
          boot_err !== 1'b0 || imem_addr !== 10'd0 || imem_wdata !== 32'd0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: rdy=%b cpurst=%b we=%b done=%b err=%b addr=%h wdata=%h required 0 1 0 0 0 0 0",
                 c, rx_ready, cpu_reset, imem_we, boot_done, boot_err, imem_addr, imem_wdata);
      end
    end
    rx_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h00000013, 0);
    send_word(32'h00100093, 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(csum, 0);
`endif
    total++;
    if (cpu_reset !== 1'b1) begin bad++; $display("FAIL basic_edge1: cpu_reset=%b required 1", cpu_reset); end
    @(negedge clk);
    total++;
    if (cpu_reset !== 1'b1) begin bad++; $display("FAIL basic_edge2: cpu_reset=%b required 1", cpu_reset); end
    @(negedge clk);
    total++;
    if (cpu_reset !== 1'b0 || boot_done !== 1'b1 || boot_err !== 1'b0 || rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_release: cpurst=%b done=%b err=%b rdy=%b required 0 1 0 0", cpu_reset, boot_done, boot_err, rx_ready);
    end
    total++;
    if (wa.size() != 2 || wa[0] !== 10'd0 || wd[0] !== 32'h00000013 || wa[1] !== 10'd1 || wd[1] !== 32'h00100093) begin
      bad++;
      $display("FAIL basic_writes: n=%0d a0=%h d0=%h a1=%h d1=%h required 2 000 00000013 001 00100093",
               wa.size(), wa[0], wd[0], wa[1], wd[1]);
    end
  endtask

  task automatic test_throttled();
    do_reset();
    send_byte(8'h02, 3); send_byte(8'h00, 3);
    send_word(32'h00000013, 3);
    send_word(32'h00100093, 3);
`ifdef BOOT_CHECKSUM_EN
    send_byte(csum, 3);
`endif
    total++;
    if (wa.size() != 2 || wa[0] !== 10'd0 || wd[0] !== 32'h00000013 || wa[1] !== 10'd1 || wd[1] !== 32'h00100093) begin
      bad++;
      $display("FAIL throttle_writes: n=%0d a0=%h d0=%h a1=%h d1=%h required 2 000 00000013 001 00100093",
               wa.size(), wa[0], wd[0], wa[1], wd[1]);
    end
    total++;
    if (cpu_reset !== 1'b0 || boot_done !== 1'b1 || boot_err !== 1'b0) begin
      bad++;
      $display("FAIL throttle_final: cpurst=%b done=%b err=%b required 0 1 0", cpu_reset, boot_done, boot_err);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h04, 0);
    @(negedge clk);
    total++;
    if (boot_err !== 1'b1 || cpu_reset !== 1'b1 || rx_ready !== 1'b0 || boot_done !== 1'b0) begin
      bad++;
      $display("FAIL oversize_err: err=%b cpurst=%b rdy=%b done=%b required 1 1 0 0", boot_err, cpu_reset, rx_ready, boot_done);
    end
    rx_valid = 1'b1; rx_data = 8'h13;
    repeat (8) @(negedge clk);
    rx_valid = 1'b0;
    total++;
    if (wa.size() != 0 || boot_err !== 1'b1 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL oversize_hold: writes=%0d err=%b cpurst=%b required 0 1 1", wa.size(), boot_err, cpu_reset);
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h93, 0); send_byte(8'h00, 0);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b0 || cpu_reset !== 1'b1 || imem_we !== 1'b0 || imem_addr !== 10'd0) begin
      bad++;
      $display("FAIL midload_reset: rdy=%b cpurst=%b we=%b addr=%h required 0 1 0 000", rx_ready, cpu_reset, imem_we, imem_addr);
    end
    do_reset();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h00000013, 0);
    send_word(32'h00100093, 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(csum, 0);
`endif
    repeat (3) @(negedge clk);
    total++;
    if (wa.size() != 2 || wa[0] !== 10'd0 || wd[0] !== 32'h00000013 || wd[1] !== 32'h00100093 || boot_done !== 1'b1) begin
      bad++;
      $display("FAIL midload_reload: n=%0d a0=%h d0=%h d1=%h done=%b required 2 000 00000013 00100093 1",
               wa.size(), wa[0], wd[0], wd[1], boot_done);
    end
  endtask

  task automatic test_zero_words();
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    repeat (3) @(negedge clk);
    total++;
    if (wa.size() != 0 || boot_done !== 1'b1 || cpu_reset !== 1'b0 || boot_err !== 1'b0) begin
      bad++;
      $display("FAIL zero_words: writes=%0d done=%b cpurst=%b err=%b required 0 1 0 0", wa.size(), boot_done, cpu_reset, boot_err);
    end
  endtask

  task automatic test_max_words();
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    for (int i = 0; i < 1024; i++) send_word(32'hA5000000 | 32'(i), 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(csum, 0);
`endif
    repeat (3) @(negedge clk);
    total++;
    if (wa.size() != 1024 || wa[1023] !== 10'd1023 || wd[1023] !== 32'hA50003FF || wd[0] !== 32'hA5000000 ||
        wa[256] !== 10'd256 || wd[256] !== 32'hA5000100) begin
      bad++;
      $display("FAIL max_words: n=%0d a_last=%h d_last=%h d0=%h a256=%h d256=%h required 1024 3ff a50003ff a5000000 100 a5000100",
               wa.size(), wa[1023], wd[1023], wd[0], wa[256], wd[256]);
    end
    total++;
    if (boot_done !== 1'b1 || boot_err !== 1'b0 || cpu_reset !== 1'b0) begin
      bad++;
      $display("FAIL max_final: done=%b err=%b cpurst=%b required 1 0 0", boot_done, boot_err, cpu_reset);
    end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'h00000013, 0);
    send_byte(8'h13, 0);
    repeat (3) @(negedge clk);
    total++;
    if (boot_done !== 1'b1 || boot_err !== 1'b0 || cpu_reset !== 1'b0 || wd.size() != 1) begin
      bad++;
      $display("FAIL csum_good: done=%b err=%b cpurst=%b writes=%0d required 1 0 0 1", boot_done, boot_err, cpu_reset, wd.size());
    end
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'h00000013, 0);
    send_byte(8'h14, 0);
    repeat (3) @(negedge clk);
    total++;
    if (boot_err !== 1'b1 || boot_done !== 1'b0 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL csum_bad: err=%b done=%b cpurst=%b required 1 0 1", boot_err, boot_done, cpu_reset);
    end
  endtask
`endif

  initial begin
    csum = 8'h00;
    test_reset();
    test_basic();
    test_throttled();
    test_oversize();
    test_reset_midload();
    test_zero_words();
    test_max_words();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/riscv_boot_loader.md
Name: riscv_boot_loader

Overview:
- Upstream stage of the single-cycle RISC-V core; fills instruction memory before the core is allowed to run.
- Accepts a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words.
- Writes each word into the instruction-memory write port.
- Holds the core in reset through its active-high reset input until the image is loaded; blocks on any loader error.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, maximum image size in words; must be <= 2**ADDR_W.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising clk edge resets the block.
- rx_data  in  8  incoming image byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- cpu_reset  out  1  active-high reset to the core.
- boot_done  out  1  image loaded; core released.
- boot_err  out  1  image rejected; core held in reset.

Behaviour:
- Reset values (reset=0 at an edge):
  - state=HDR0; cpu_reset=1; rx_ready=0 for that cycle.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - boot_done=0, boot_err=0.
  - Byte, word and checksum counters cleared.
  - Reset mid-load discards partial state; the load restarts from the header.
- Byte transfer:
  - A byte is taken only when rx_valid&&rx_ready at a rising edge.
  - rx_ready=1 only in HDR0, HDR1, LOAD and CSUM; registered, so it is high from the first cycle after reset release.
- Stream format:
  - 2-byte word count N, LSB first.
  - Then 4*N payload bytes; byte0 of each word goes to wdata[7:0], byte3 to wdata[31:24].
- States:
  - HDR0: take count LSB -> HDR1.
  - HDR1: take count MSB; compute N.
    - N==0 -> FLUSH (CSUM if the macro is on).
    - N>MAX_WORDS -> ERR.
    - Otherwise -> LOAD.
  - LOAD: shift bytes into the word register.
    - On the 4th byte of word i, at that same edge: imem_we=1, imem_addr=i, imem_wdata=word. Strobe high exactly one cycle.
    - After word N-1 -> FLUSH (CSUM if the macro is on).
  - FLUSH: one idle cycle so the last write commits -> DONE.
  - DONE: cpu_reset=0, boot_done=1; rx_ready=0. Remains here until reset.
  - ERR: boot_err=1, cpu_reset=1, rx_ready=0. Remains here until reset.
- Latency: imem_we rises at the edge accepting the word's 4th byte; write commits at the following edge.
  - cpu_reset falls 2 edges after the last payload byte is accepted, so the first core fetch sees the complete image.
- Timing: rx_valid gaps of any length are tolerated; counters hold while no byte is accepted.
- Boundaries:
  - N==MAX_WORDS is legal; imem_addr reaches MAX_WORDS-1 and does not wrap.
  - Word counter is ADDR_W+1 bits wide.
  - Bytes presented in DONE or ERR are ignored.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - After the payload, one extra byte in state CSUM equals the 8-bit modulo-256 sum of all 4*N payload bytes (header excluded).
  - Match -> FLUSH -> DONE.
  - Mismatch -> ERR.
  - N==0 expects checksum 0x00.
- Undefined: CSUM state and the sum register are absent; the payload goes straight to FLUSH.

Test Plan:
- Reset hold: reset=0 for 3 cycles with rx_valid=1 -> rx_ready=0, cpu_reset=1, imem_we=0, boot_done=0 throughout.
- Basic load: bytes 02 00, 13 00 00 00, 93 00 10 00 -> two single-cycle writes:
  - addr0=0x00000013, addr1=0x00100093;
  - cpu_reset falls exactly 2 edges after the last byte; boot_done=1.
- Throttled input: same image with rx_valid low 3 cycles between every byte -> identical writes and final state.
- Oversize: header 01 04 (N=1025) with MAX_WORDS=1024 -> ERR, boot_err=1, cpu_reset=1, no imem_we.
- Reset mid-load: reset asserted after 6 payload bytes, then the full basic image -> only words from the second pass written, addr0 correct.
- Checksum (BOOT_CHECKSUM_EN): header 01 00, payload 13 00 00 00:
  - checksum 0x13 -> DONE;
  - checksum 0x14 -> boot_err=1, cpu_reset remains 1.
